fourteen_to_one_serializer_fsm: RTL and testbench

//  Parallel-to-serial transmit stage feeding the 1-to-14 deserializer FSM.

---
 rtl/fourteen_to_one_serializer_fsm_if.sv | 31 +++
 rtl/fourteen_to_one_serializer_fsm.sv | 137 +++++++++++++
 tb/tb_fourteen_to_one_serializer_fsm.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fourteen_to_one_serializer_fsm_if.sv
// Handshake/bus bundle between the serializer and its host plus receiver.
//   start, data_in  : host send request and parallel word
//   rx_ready        : receiver ready
//   ss, sdata, ack  : frame strobe, serial data, acknowledge to the receiver
//   busy, done, err : status back to the host
//   state_q         : FSM encoding for LEDs
// master = host/receiver side (testbench), slave = serializer.
interface fourteen_to_one_serializer_fsm_if #(
  parameter int WIDTH = 14
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             rx_ready;
  logic             ss;
  logic             sdata;
  logic             ack;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       state_q;

  modport master (
    output start, data_in, rx_ready,
    input  ss, sdata, ack, busy, done, err, state_q
  );

  modport slave (
    input  start, data_in, rx_ready,
    output ss, sdata, ack, busy, done, err, state_q
  );
endinterface

// File: rtl/fourteen_to_one_serializer_fsm.sv
// Parallel-to-serial transmit stage for the 1-to-14 deserializer.
// Latches a WIDTH-bit word on start, holds ss high for WIDTH cycles while
// shifting the word out MSB-first on sdata, then waits for rx_ready and
// runs a ready/ack handshake. done pulses on completion, err pulses when
// rx_ready never arrives within TIMEOUT cycles.
// Ports:
//   clock  : system clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : slave side of fourteen_to_one_serializer_fsm_if
// All outputs are registered.
module fourteen_to_one_serializer_fsm #(
  parameter int WIDTH   = 14,
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic resetn,
  fourteen_to_one_serializer_fsm_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SHIFT    = 2'b01,
    WAIT_RDY = 2'b10,
    ACK      = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [TW-1:0]    tcnt_q,  tcnt_d;
  logic             ss_q,    ss_d;
  logic             sdata_q, sdata_d;
  logic             ack_q,   ack_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             err_q,   err_d;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    ss_d    = ss_q;
    sdata_d = sdata_q;
    ack_d   = ack_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A done/err pulse cycle is still the tail of the previous frame,
        // so start is not accepted there.
        if (bus.start && !done_q && !err_q) begin
          state_d = SHIFT;
          // MSB goes straight to the sdata flop; shreg keeps the rest.
          sdata_d = bus.data_in[WIDTH-1];
          shreg_d = bus.data_in << 1;
          cnt_d   = '0;
          ss_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = WAIT_RDY;
          ss_d    = 1'b0;
          sdata_d = 1'b0;
          tcnt_d  = '0;
        end else begin
          sdata_d = shreg_q[WIDTH-1];
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      WAIT_RDY: begin
        if (bus.rx_ready) begin
          state_d = ACK;
          ack_d   = 1'b1;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else begin
          tcnt_d  = tcnt_q + 1'b1;
        end
      end
      ACK: begin
        if (!bus.rx_ready) begin
          state_d = IDLE;
          ack_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      ss_q    <= 1'b0;
      sdata_q <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      ss_q    <= ss_d;
      sdata_q <= sdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.ss      = ss_q;
  assign bus.sdata   = sdata_q;
  assign bus.ack     = ack_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.state_q = state_q;

endmodule

// File: tb/tb_fourteen_to_one_serializer_fsm.sv
module tb_fourteen_to_one_serializer_fsm;
  localparam int W  = 14;
  localparam int TO = 8;

  logic clock;
  logic resetn;
  int   checks   = 0;
  int   failures = 0;

  fourteen_to_one_serializer_fsm_if #(.WIDTH(W)) bus ();

  fourteen_to_one_serializer_fsm #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, ".ss"},    32'(bus.ss),      0);
    chk({tag, ".sdata"}, 32'(bus.sdata),   0);
    chk({tag, ".ack"},   32'(bus.ack),     0);
    chk({tag, ".busy"},  32'(bus.busy),    0);
    chk({tag, ".done"},  32'(bus.done),    0);
    chk({tag, ".err"},   32'(bus.err),     0);
    chk({tag, ".state"}, 32'(bus.state_q), 0);
  endtask

  // Receiver model: captures sdata while ss is high, then raises rx_ready
  // until ack, drops it and expects done. Every wait is bounded.
  task automatic e2e(input logic [W-1:0] word);
    logic [W-1:0] rx;
    int n;
    int t;
    rx = '0;
    n  = 0;
    bus.data_in = word;
    bus.start   = 1'b1;
    @(negedge clock);
    bus.start   = 1'b0;
    t = 0;
    while (bus.ss && t < 40) begin
      rx = {rx[W-2:0], bus.sdata};
      n++;
      t++;
      @(negedge clock);
    end
    chk("e2e.nbits", 32'(n), W);
    chk("e2e.word",  32'(rx), 32'(word));
    bus.rx_ready = 1'b1;
    t = 0;
    while (!bus.ack && t < 20) begin
      t++;
      @(negedge clock);
    end
    chk("e2e.ack", 32'(bus.ack), 1);
    bus.rx_ready = 1'b0;
    t = 0;
    while (!bus.done && t < 20) begin
      t++;
      @(negedge clock);
    end
    chk("e2e.done", 32'(bus.done), 1);
    @(negedge clock);
  endtask

  initial begin
    logic [W-1:0] w;
    logic [W-1:0] rx;
    int donecnt;

    resetn       = 1'b0;
    bus.start    = 1'b0;
    bus.data_in  = '0;
    bus.rx_ready = 1'b0;
    repeat (2) @(negedge clock);
    idle_chk("rst");
    resetn = 1'b1;
    @(negedge clock);
    idle_chk("idle");

    // Reset mid-SHIFT clears outputs without any clock edge.
    bus.data_in = 14'h3FFF;
    bus.start   = 1'b1;
    @(negedge clock);
    bus.start   = 1'b0;
    repeat (3) @(negedge clock);
    chk("pre_rst.ss", 32'(bus.ss), 1);
    #2 resetn = 1'b0;
    #1 idle_chk("async_rst");
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    // Frame 14'h2CE5; data_in changes after latch must not matter.
    w = 14'h2CE5;
    bus.data_in = w;
    bus.start   = 1'b1;
    @(negedge clock);
    bus.start   = 1'b0;
    bus.data_in = '0;
    bus.rx_ready = 1'b1;       // ignored during SHIFT
    chk("frame.state", 32'(bus.state_q), 32'h1);
    chk("frame.busy",  32'(bus.busy), 1);
    for (int i = 0; i < W; i++) begin
      chk($sformatf("frame.ss%0d", i),  32'(bus.ss), 1);
      chk($sformatf("frame.bit%0d", i), 32'(bus.sdata), 32'(w[W-1-i]));
      if (i == W - 2) bus.rx_ready = 1'b0;
      @(negedge clock);
    end
    chk("frame.ss_fall", 32'(bus.ss), 0);
    chk("frame.wait",    32'(bus.state_q), 32'h2);
    chk("frame.sd0",     32'(bus.sdata), 0);

    // Handshake: rx_ready 3 cycles after ss falls, high for 2 cycles.
    repeat (2) @(negedge clock);
    chk("hs.still_wait", 32'(bus.state_q), 32'h2);
    bus.rx_ready = 1'b1;
    @(negedge clock);
    chk("hs.ack1",   32'(bus.ack), 1);
    chk("hs.state3", 32'(bus.state_q), 32'h3);
    chk("hs.done0",  32'(bus.done), 0);
    @(negedge clock);
    chk("hs.ack2",   32'(bus.ack), 1);
    bus.rx_ready = 1'b0;
    @(negedge clock);
    chk("hs.ack_off", 32'(bus.ack), 0);
    chk("hs.done",    32'(bus.done), 1);
    chk("hs.err",     32'(bus.err), 0);
    chk("hs.idle",    32'(bus.state_q), 0);
    chk("hs.busy",    32'(bus.busy), 0);
    // start during the done cycle is ignored; it takes on the next edge.
    bus.data_in = '0;
    bus.start   = 1'b1;
    @(negedge clock);
    chk("hs.done_once", 32'(bus.done), 0);
    chk("hs.start_ign", 32'(bus.state_q), 0);
    @(negedge clock);
    bus.start = 1'b0;
    chk("to.shift", 32'(bus.state_q), 32'h1);

    // Timeout: TIMEOUT=8, rx_ready held low.
    repeat (W) @(negedge clock);
    for (int k = 1; k <= TO; k++) begin
      chk($sformatf("to.wait%0d", k), 32'(bus.state_q), 32'h2);
      chk($sformatf("to.err0_%0d", k), 32'(bus.err), 0);
      @(negedge clock);
    end
    chk("to.err",   32'(bus.err), 1);
    chk("to.done",  32'(bus.done), 0);
    chk("to.idle",  32'(bus.state_q), 0);
    @(negedge clock);
    chk("to.err_pulse", 32'(bus.err), 0);

    // Ignored start mid-frame of 14'h0001.
    bus.data_in = 14'h0001;
    bus.start   = 1'b1;
    @(negedge clock);
    bus.start   = 1'b0;
    rx = '0;
    for (int i = 0; i < W; i++) begin
      rx = {rx[W-2:0], bus.sdata};
      if (i == 5) begin
        bus.data_in = 14'h3FFF;
        bus.start   = 1'b1;
      end else begin
        bus.start   = 1'b0;
      end
      @(negedge clock);
    end
    chk("ign.stream", 32'(rx), 32'h0001);
    bus.rx_ready = 1'b1;
    @(negedge clock);
    bus.rx_ready = 1'b0;
    @(negedge clock);
    chk("ign.done", 32'(bus.done), 1);
    donecnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (bus.ss) donecnt++;
    end
    chk("ign.no_second", 32'(donecnt), 0);

    // End-to-end against the receiver model.
    e2e(14'h0000);
    e2e(14'h3FFF);
    e2e(14'h1555);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
